// File: rtl/rif_sram_slv.sv
`timescale 1ns/1ps
// rif_sram_slv: RIF slave that terminates one RIF master port into a
// single-ported, byte-enabled on-chip RAM. Accepts one read or write per cycle.
// Read data returns in request order through a 2-entry response buffer, so
// one read per cycle is sustained while read-data back-pressure is tolerated.
//
// Handshake semantics (both channels): a beat transfers on a rising edge where
// valid and ready are both 1. A master holds valid and payload stable until
// the transfer. rif_rdy is derived from registered state only and never
// depends combinationally on rif_val, rif_we or rif_rdata_rdy.
module rif_sram_slv #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int NBE   = DW / 8,
    parameter int DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rif_val,
    output logic           rif_rdy,
    input  logic [AW-1:0]  rif_addr,
    input  logic [DW-1:0]  rif_wdata,
    input  logic           rif_we,
    input  logic [NBE-1:0] rif_be,
    output logic           rif_rdata_val,
    input  logic           rif_rdata_rdy,
    output logic [DW-1:0]  rif_rdata
);

    // Byte-offset bits below the word index, and word-index width.
    localparam int OW = $clog2(NBE);
    localparam int IW = $clog2(DEPTH);

    // Storage: the RAM itself is never reset; the response buffer holds data only.
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] rbuf [2];

    // Response buffer bookkeeping; 1-bit pointers wrap naturally over 2 entries.
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;

    logic [IW-1:0] word_idx;
    logic          req_fire;
    logic          rd_fire;
    logic          wr_fire;
    logic          pop;

    // Address bits outside the word index are deliberately ignored: low bits
    // carry no misalignment error, high bits alias modulo the RAM size.
    logic unused_addr_bits;

    assign word_idx = rif_addr[OW+IW-1:OW];
    assign unused_addr_bits = ^{rif_addr[AW-1:OW+IW], rif_addr[OW-1:0]};

    // Request side stalls whenever the buffer is full (writes too), which keeps
    // ordering trivial: nothing is accepted that could overtake a stuck read.
    assign rif_rdy  = !rst && (cnt != 2'd2);
    assign req_fire = rif_val && rif_rdy;
    assign rd_fire  = req_fire && !rif_we;
    assign wr_fire  = req_fire && rif_we;

    // Head of the buffer is always presented; data is forced to 0 when empty
    // or in reset so the bus never shows stale words.
    assign rif_rdata_val = !rst && (cnt != 2'd0);
    assign rif_rdata     = rif_rdata_val ? rbuf[rd_ptr] : '0;
    assign pop           = rif_rdata_val && rif_rdata_rdy;

    // Byte-lane write: only enabled lanes change; be == 0 is a legal no-op.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < NBE; i++) begin
                if (rif_be[i]) begin
                    mem[word_idx][i*8 +: 8] <= rif_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read capture: the whole word goes into the buffer at the acceptance edge,
    // so a write accepted one edge earlier is already visible here.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            rbuf[wr_ptr] <= mem[word_idx];
        end
    end

    // Pointer and occupancy update; a push and pop in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (rd_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({rd_fire, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_rif_sram_slv.sv
`timescale 1ns/1ps
// Directed testbench for rif_sram_slv (default parameters: AW=16, DW=32,
// DEPTH=1024). Inputs change 1 ns after a rising edge; outputs are compared
// in the same window, well away from the next active edge.
module tb_rif_sram_slv;

    logic        clk = 1'b0;
    logic        rst;
    logic        rif_val;
    logic        rif_rdy;
    logic [15:0] rif_addr;
    logic [31:0] rif_wdata;
    logic        rif_we;
    logic [3:0]  rif_be;
    logic        rif_rdata_val;
    logic        rif_rdata_rdy;
    logic [31:0] rif_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    rif_sram_slv dut (
        .clk          (clk),
        .rst          (rst),
        .rif_val      (rif_val),
        .rif_rdy      (rif_rdy),
        .rif_addr     (rif_addr),
        .rif_wdata    (rif_wdata),
        .rif_we       (rif_we),
        .rif_be       (rif_be),
        .rif_rdata_val(rif_rdata_val),
        .rif_rdata_rdy(rif_rdata_rdy),
        .rif_rdata    (rif_rdata)
    );

    // Clock and global watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: single write with bounded wait for rif_rdy
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        rif_val = 1'b1; rif_we = 1'b1; rif_addr = a; rif_wdata = d; rif_be = be;
        while (rif_rdy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (rif_rdy !== 1'b1) $display("FAIL write_rdy_timeout: got rdy=%b expected 1", rif_rdy);
        else n_pass++;
        step();
        rif_val = 1'b0; rif_we = 1'b0;
    endtask

    // Driver: single read with rdata_rdy=1 and an empty buffer; checks
    // 1-cycle latency, data, and that the response is popped the next edge.
    task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input string name);
        rif_rdata_rdy = 1'b1;
        rif_val = 1'b1; rif_we = 1'b0; rif_addr = a; rif_be = 4'h0;
        n_checks++;
        if (rif_rdy !== 1'b1 || rif_rdata_val !== 1'b0)
            $display("FAIL %s_pre: got rdy=%b val=%b expected rdy=1 val=0", name, rif_rdy, rif_rdata_val);
        else n_pass++;
        step();
        rif_val = 1'b0;
        n_checks++;
        if (rif_rdata_val !== 1'b1 || rif_rdata !== exp)
            $display("FAIL %s_data: got val=%b data=%h expected val=1 data=%h", name, rif_rdata_val, rif_rdata, exp);
        else n_pass++;
        step();
        n_checks++;
        if (rif_rdata_val !== 1'b0)
            $display("FAIL %s_pop: got val=%b expected 0", name, rif_rdata_val);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rif_val = 1'b0; rif_we = 1'b0; rif_addr = '0; rif_wdata = '0;
        rif_be = '0; rif_rdata_rdy = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if (rif_rdy !== 1'b0 || rif_rdata_val !== 1'b0 || rif_rdata !== 32'h0)
                $display("FAIL reset_outputs: got rdy=%b val=%b data=%h expected 0 0 00000000",
                         rif_rdy, rif_rdata_val, rif_rdata);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rif_rdy !== 1'b1 || rif_rdata_val !== 1'b0)
            $display("FAIL reset_release: got rdy=%b val=%b expected rdy=1 val=0", rif_rdy, rif_rdata_val);
        else n_pass++;
        step();
    endtask

    // Write immediately followed by a read of the same word
    task automatic test_basic();
        do_write(16'h0000, 32'hA5A5_0001, 4'hF);
        do_read(16'h0000, 32'hA5A5_0001, "basic");
    endtask

    task automatic test_byte_enable();
        do_write(16'h0010, 32'hFFFF_FFFF, 4'hF);
        do_write(16'h0010, 32'h1122_3344, 4'h5);
        do_read(16'h0012, 32'hFF22_FF44, "byte_en");
        do_write(16'h0000, 32'h0BAD_0BAD, 4'h0);
        do_read(16'h0003, 32'hA5A5_0001, "be_zero_noop");
    endtask

    task automatic test_alias();
        do_write(16'h1004, 32'hDEAD_BEEF, 4'hF);
        do_read(16'h0004, 32'hDEAD_BEEF, "alias");
    endtask

    task automatic test_back_pressure();
        do_write(16'h0020, 32'h0000_0001, 4'hF);
        do_write(16'h0024, 32'h0000_0002, 4'hF);
        do_write(16'h0028, 32'h0000_0003, 4'hF);
        rif_rdata_rdy = 1'b0;
        rif_val = 1'b1; rif_we = 1'b0; rif_be = 4'h0; rif_addr = 16'h0020;
        n_checks++;
        if (rif_rdy !== 1'b1 || rif_rdata_val !== 1'b0)
            $display("FAIL bp_first: got rdy=%b val=%b expected 1 0", rif_rdy, rif_rdata_val);
        else n_pass++;
        step();
        rif_addr = 16'h0024;
        n_checks++;
        if (rif_rdy !== 1'b1 || rif_rdata_val !== 1'b1 || rif_rdata !== 32'h1)
            $display("FAIL bp_second: got rdy=%b val=%b data=%h expected 1 1 00000001", rif_rdy, rif_rdata_val, rif_rdata);
        else n_pass++;
        step();
        rif_addr = 16'h0028;
        n_checks++;
        if (rif_rdy !== 1'b0 || rif_rdata_val !== 1'b1 || rif_rdata !== 32'h1)
            $display("FAIL bp_full: got rdy=%b val=%b data=%h expected 0 1 00000001", rif_rdy, rif_rdata_val, rif_rdata);
        else n_pass++;
        step();
        n_checks++;
        if (rif_rdy !== 1'b0 || rif_rdata_val !== 1'b1 || rif_rdata !== 32'h1)
            $display("FAIL bp_stable: got rdy=%b val=%b data=%h expected 0 1 00000001", rif_rdy, rif_rdata_val, rif_rdata);
        else n_pass++;
        rif_rdata_rdy = 1'b1;
        step();
        n_checks++;
        if (rif_rdy !== 1'b1 || rif_rdata_val !== 1'b1 || rif_rdata !== 32'h2)
            $display("FAIL bp_after_pop: got rdy=%b val=%b data=%h expected 1 1 00000002", rif_rdy, rif_rdata_val, rif_rdata);
        else n_pass++;
        step();
        rif_val = 1'b0;
        n_checks++;
        if (rif_rdata_val !== 1'b1 || rif_rdata !== 32'h3)
            $display("FAIL bp_third: got val=%b data=%h expected 1 00000003", rif_rdata_val, rif_rdata);
        else n_pass++;
        step();
        n_checks++;
        if (rif_rdata_val !== 1'b0 || rif_rdy !== 1'b1)
            $display("FAIL bp_drain: got val=%b rdy=%b expected 0 1", rif_rdata_val, rif_rdy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            do_write(16'h0100 + 16'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF);
        end
        exp_q.delete();
        rif_rdata_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rif_val = 1'b1; rif_we = 1'b0; rif_be = 4'h0; rif_addr = 16'h0100 + 16'(i * 4);
            n_checks++;
            if (rif_rdy !== 1'b1) $display("FAIL stream_rdy: cycle %0d got rdy=%b expected 1", i, rif_rdy);
            else n_pass++;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rif_rdata_val !== 1'b1 || rif_rdata !== e)
                    $display("FAIL stream_data: cycle %0d got val=%b data=%h expected 1 %h", i, rif_rdata_val, rif_rdata, e);
                else n_pass++;
            end
            exp_q.push_back(32'hC0DE_0000 + 32'(i));
            step();
        end
        rif_val = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (rif_rdata_val !== 1'b1 || rif_rdata !== e)
            $display("FAIL stream_last: got val=%b data=%h expected 1 %h", rif_rdata_val, rif_rdata, e);
        else n_pass++;
        step();
        n_checks++;
        if (rif_rdata_val !== 1'b0)
            $display("FAIL stream_end: got val=%b expected 0", rif_rdata_val);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rif_rdata_rdy = 1'b0;
        rif_val = 1'b1; rif_we = 1'b0; rif_be = 4'h0; rif_addr = 16'h0020;
        step();
        rif_addr = 16'h0024;
        step();
        rif_val = 1'b0;
        n_checks++;
        if (rif_rdata_val !== 1'b1 || rif_rdy !== 1'b0)
            $display("FAIL rstmid_full: got val=%b rdy=%b expected 1 0", rif_rdata_val, rif_rdy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rif_rdata_val !== 1'b0 || rif_rdy !== 1'b0)
            $display("FAIL rstmid_during: got val=%b rdy=%b expected 0 0", rif_rdata_val, rif_rdy);
        else n_pass++;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (rif_rdata_val !== 1'b0 || rif_rdy !== 1'b1)
            $display("FAIL rstmid_after: got val=%b rdy=%b expected 0 1", rif_rdata_val, rif_rdy);
        else n_pass++;
        rif_rdata_rdy = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if (rif_rdata_val !== 1'b0)
                $display("FAIL rstmid_stale: got val=%b expected 0", rif_rdata_val);
            else n_pass++;
        end
        do_read(16'h0020, 32'h0000_0001, "rstmid_mem0");
        do_read(16'h0024, 32'h0000_0002, "rstmid_mem1");
        do_read(16'h0000, 32'hA5A5_0001, "rstmid_mem2");
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_alias();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
